// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve timing, ball step rate, scoring and game-over.
// The only block holding game state; all outputs are registered.
module pong_game_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int BALL_DIV     = 2,
  parameter int SCORE_LIMIT  = 9
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Frame_end,
  input  logic       i_Start,
  input  logic       i_Miss_P1,
  input  logic       i_Miss_P2,
  output logic       o_Game_active,
  output logic       o_Ball_step,
  output logic       o_Ball_reset,
  output logic [3:0] o_P1_score,
  output logic [3:0] o_P2_score,
  output logic [1:0] o_Winner,
  output logic [2:0] o_State
);

  localparam int SW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES + 1) : 1;
  localparam int DW = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_FRAMES - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(BALL_DIV - 1);
  localparam logic [3:0]    LIMIT      = 4'(SCORE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SERVE    = 3'd1,
    S_PLAY     = 3'd2,
    S_POINT    = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  state_t        state, state_d;
  logic          start_q, start_rise;
  logic [SW-1:0] serve_cnt, serve_cnt_d;
  logic [DW-1:0] div_cnt, div_cnt_d;
  logic [3:0]    p1_d, p2_d, p1_inc, p2_inc;
  logic [1:0]    win_d;
  logic          step_d, breset_d, active_d;

  assign start_rise = i_Start & ~start_q;
  assign p1_inc     = o_P1_score + 4'd1;
  assign p2_inc     = o_P2_score + 4'd1;
  assign o_State    = state;

  always_ff @(posedge i_Clk) begin
    if (i_Reset) state <= S_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:     if (start_rise) state_d = S_SERVE;
      S_SERVE:    if (i_Frame_end && serve_cnt == SERVE_LAST) state_d = S_PLAY;
      S_PLAY: begin
        // A double miss is a replay; otherwise the scoring side may end the game.
        if (i_Miss_P1 && i_Miss_P2) state_d = S_POINT;
        else if (i_Miss_P2)         state_d = (p1_inc == LIMIT) ? S_GAMEOVER : S_POINT;
        else if (i_Miss_P1)         state_d = (p2_inc == LIMIT) ? S_GAMEOVER : S_POINT;
      end
      S_POINT:    state_d = S_SERVE;
      S_GAMEOVER: if (start_rise) state_d = S_SERVE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    p1_d        = o_P1_score;
    p2_d        = o_P2_score;
    win_d       = o_Winner;
    serve_cnt_d = serve_cnt;
    div_cnt_d   = div_cnt;
    step_d      = 1'b0;
    case (state)
      S_IDLE: begin
        p1_d  = 4'd0;
        p2_d  = 4'd0;
        win_d = 2'd0;
      end
      S_SERVE: begin
        if (i_Frame_end) serve_cnt_d = serve_cnt + 1'b1;
        if (state_d == S_PLAY) div_cnt_d = '0;
      end
      S_PLAY: begin
        if (i_Miss_P1 || i_Miss_P2) begin
          if (i_Miss_P2 && !i_Miss_P1) begin
            p1_d = p1_inc;
            if (p1_inc == LIMIT) win_d = 2'd1;
          end else if (i_Miss_P1 && !i_Miss_P2) begin
            p2_d = p2_inc;
            if (p2_inc == LIMIT) win_d = 2'd2;
          end
        end else if (i_Frame_end) begin
          if (div_cnt == DIV_LAST) begin
            div_cnt_d = '0;
            step_d    = 1'b1;
          end else begin
            div_cnt_d = div_cnt + 1'b1;
          end
        end
      end
      S_GAMEOVER: begin
        if (start_rise) begin
          p1_d  = 4'd0;
          p2_d  = 4'd0;
          win_d = 2'd0;
        end
      end
      default: ;
    endcase
    breset_d = (state_d == S_SERVE) && (state != S_SERVE);
    if (breset_d) serve_cnt_d = '0;
    active_d = (state_d == S_PLAY);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      start_q       <= 1'b1;
      serve_cnt     <= '0;
      div_cnt       <= '0;
      o_P1_score    <= 4'd0;
      o_P2_score    <= 4'd0;
      o_Winner      <= 2'd0;
      o_Ball_step   <= 1'b0;
      o_Ball_reset  <= 1'b0;
      o_Game_active <= 1'b0;
    end else begin
      start_q       <= i_Start;
      serve_cnt     <= serve_cnt_d;
      div_cnt       <= div_cnt_d;
      o_P1_score    <= p1_d;
      o_P2_score    <= p2_d;
      o_Winner      <= win_d;
      o_Ball_step   <= step_d;
      o_Ball_reset  <= breset_d;
      o_Game_active <= active_d;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: vector table plus step-rate and mid-game reset sequences.
module tb_pong_game_ctrl;

  logic       i_Clk = 1'b0;
  logic       i_Reset, i_Frame_end, i_Start, i_Miss_P1, i_Miss_P2;
  logic       o_Game_active, o_Ball_step, o_Ball_reset;
  logic [3:0] o_P1_score, o_P2_score;
  logic [1:0] o_Winner;
  logic [2:0] o_State;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] IDL = 3'd0, SRV = 3'd1, PLY = 3'd2, PNT = 3'd3, GOV = 3'd4;

  pong_game_ctrl #(.SERVE_FRAMES(3), .BALL_DIV(2), .SCORE_LIMIT(3)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Frame_end(i_Frame_end), .i_Start(i_Start),
    .i_Miss_P1(i_Miss_P1), .i_Miss_P2(i_Miss_P2), .o_Game_active(o_Game_active),
    .o_Ball_step(o_Ball_step), .o_Ball_reset(o_Ball_reset), .o_P1_score(o_P1_score),
    .o_P2_score(o_P2_score), .o_Winner(o_Winner), .o_State(o_State)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic       rst, start, fe, m1, m2;
    logic [2:0] st;
    logic       act, step, brst;
    logic [3:0] p1, p2;
    logic [1:0] win;
  } vec_t;

  function automatic vec_t mk(logic rst, logic start, logic fe, logic m1, logic m2,
                              logic [2:0] st, logic act, logic step, logic brst,
                              logic [3:0] p1, logic [3:0] p2, logic [1:0] win);
    vec_t v;
    v.rst = rst; v.start = start; v.fe = fe; v.m1 = m1; v.m2 = m2;
    v.st = st; v.act = act; v.step = step; v.brst = brst;
    v.p1 = p1; v.p2 = p2; v.win = win;
    return v;
  endfunction

  task automatic chk(input string name, input string tag, input int idx,
                     input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d] %s: got %0d expected %0d", tag, idx, name, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then check outputs just after the edge.
  task automatic apply(input vec_t v, input string tag, input int idx);
    @(negedge i_Clk);
    i_Reset = v.rst; i_Start = v.start; i_Frame_end = v.fe;
    i_Miss_P1 = v.m1; i_Miss_P2 = v.m2;
    @(posedge i_Clk);
    #1;
    chk("state",   tag, idx, {5'd0, o_State},       {5'd0, v.st});
    chk("active",  tag, idx, {7'd0, o_Game_active}, {7'd0, v.act});
    chk("step",    tag, idx, {7'd0, o_Ball_step},   {7'd0, v.step});
    chk("breset",  tag, idx, {7'd0, o_Ball_reset},  {7'd0, v.brst});
    chk("p1",      tag, idx, {4'd0, o_P1_score},    {4'd0, v.p1});
    chk("p2",      tag, idx, {4'd0, o_P2_score},    {4'd0, v.p2});
    chk("winner",  tag, idx, {6'd0, o_Winner},      {6'd0, v.win});
  endtask

  vec_t tbl[$];

  initial begin
    int sc, dv;
    logic [2:0] est;
    logic estep;
    i_Reset = 1'b1; i_Start = 1'b1; i_Frame_end = 1'b0; i_Miss_P1 = 1'b0; i_Miss_P2 = 1'b0;

    //          rst st fe m1 m2   state act stp brs p1 p2 win
    tbl.push_back(mk(1, 1, 0, 0, 0, IDL, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, IDL, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, IDL, 0, 0, 0, 0, 0, 0)); // held start: no game
    tbl.push_back(mk(0, 1, 0, 0, 0, IDL, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, IDL, 0, 0, 0, 0, 0, 0)); // miss in IDLE ignored
    tbl.push_back(mk(0, 1, 0, 0, 0, SRV, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, SRV, 0, 0, 0, 0, 0, 0)); // miss in SERVE ignored
    tbl.push_back(mk(0, 1, 1, 0, 0, SRV, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, SRV, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, SRV, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, PLY, 1, 0, 0, 0, 0, 0)); // third frame end
    tbl.push_back(mk(0, 1, 1, 0, 0, PLY, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, PLY, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, PLY, 1, 1, 0, 0, 0, 0)); // 2nd frame end: step
    tbl.push_back(mk(0, 0, 0, 0, 0, PLY, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, PLY, 1, 0, 0, 0, 0, 0)); // start rise in PLAY ignored
    tbl.push_back(mk(0, 1, 1, 0, 0, PLY, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 1, PNT, 0, 0, 0, 1, 0, 0)); // miss beats qualifying frame end
    tbl.push_back(mk(0, 1, 0, 0, 0, SRV, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, SRV, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, SRV, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, PLY, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, PNT, 0, 0, 0, 1, 0, 0)); // double miss: replay
    tbl.push_back(mk(0, 1, 0, 0, 0, SRV, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, SRV, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, SRV, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, PLY, 1, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, PNT, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, SRV, 0, 0, 1, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, SRV, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, SRV, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, PLY, 1, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, PNT, 0, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, SRV, 0, 0, 1, 2, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, SRV, 0, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, SRV, 0, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, PLY, 1, 0, 0, 2, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, GOV, 0, 0, 0, 3, 1, 1)); // limit reached
    tbl.push_back(mk(0, 1, 0, 1, 0, GOV, 0, 0, 0, 3, 1, 1)); // miss in GAMEOVER ignored
    tbl.push_back(mk(0, 0, 0, 0, 0, GOV, 0, 0, 0, 3, 1, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, SRV, 0, 0, 1, 0, 0, 0)); // restart clears

    foreach (tbl[i]) apply(tbl[i], "tbl", i);

    // Frame end every 10 cycles from a fresh SERVE; reference model of serve count and divider.
    sc = 0; dv = 0; est = SRV;
    for (int i = 0; i < 80; i++) begin
      logic fe;
      fe = (i % 10 == 9);
      estep = 1'b0;
      if (fe && est == SRV) begin
        sc++;
        if (sc == 3) begin est = PLY; dv = 0; end
      end else if (fe && est == PLY) begin
        if (dv == 1) begin dv = 0; estep = 1'b1; end
        else dv++;
      end
      apply(mk(0, 1, fe, 0, 0, est, est == PLY, estep, 0, 0, 0, 0), "rate", i);
    end

    // Build P2 score to 2, then reset mid-PLAY.
    apply(mk(0, 1, 0, 1, 0, PNT, 0, 0, 0, 0, 1, 0), "seq", 0);
    apply(mk(0, 1, 0, 0, 0, SRV, 0, 0, 1, 0, 1, 0), "seq", 1);
    apply(mk(0, 1, 1, 0, 0, SRV, 0, 0, 0, 0, 1, 0), "seq", 2);
    apply(mk(0, 1, 1, 0, 0, SRV, 0, 0, 0, 0, 1, 0), "seq", 3);
    apply(mk(0, 1, 1, 0, 0, PLY, 1, 0, 0, 0, 1, 0), "seq", 4);
    apply(mk(0, 1, 0, 1, 0, PNT, 0, 0, 0, 0, 2, 0), "seq", 5);
    apply(mk(0, 1, 0, 0, 0, SRV, 0, 0, 1, 0, 2, 0), "seq", 6);
    apply(mk(0, 1, 1, 0, 0, SRV, 0, 0, 0, 0, 2, 0), "seq", 7);
    apply(mk(0, 1, 1, 0, 0, SRV, 0, 0, 0, 0, 2, 0), "seq", 8);
    apply(mk(0, 1, 1, 0, 0, PLY, 1, 0, 0, 0, 2, 0), "seq", 9);
    apply(mk(0, 1, 0, 0, 0, PLY, 1, 0, 0, 0, 2, 0), "seq", 10);
    apply(mk(1, 1, 1, 1, 0, IDL, 0, 0, 0, 0, 0, 0), "seq", 11); // reset beats everything
    apply(mk(0, 1, 0, 0, 0, IDL, 0, 0, 0, 0, 0, 0), "seq", 12);
    apply(mk(0, 0, 0, 0, 0, IDL, 0, 0, 0, 0, 0, 0), "seq", 13);
    apply(mk(0, 1, 0, 0, 0, SRV, 0, 0, 1, 0, 0, 0), "seq", 14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Top-level game sequencer for Pong. It consumes the per-frame end-of-frame pulse from the frame counter and the miss events from the ball logic. It controls ball serving, ball stepping rate, scoring and game-over. It sits between the frame counter and the ball/paddle/score-display blocks and is the only place game state is held.

## Interface
- SERVE_FRAMES, default 60: frames spent in SERVE before play starts (≥1).
- BALL_DIV, default 2: ball steps once every BALL_DIV frames during PLAY (≥1).
- SCORE_LIMIT, default 9: score that ends the game (1..15).

- i_Clk  in  1  system/pixel clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Frame_end  in  1  one-cycle pulse on the last pixel of each frame.
- i_Start  in  1  debounced start button level; rising edge detected internally.
- i_Miss_P1  in  1  pulse: ball passed player-1 edge (point to P2).
- i_Miss_P2  in  1  pulse: ball passed player-2 edge (point to P1).
- o_Game_active  out  1  high while in PLAY; enables paddles and ball motion.
- o_Ball_step  out  1  one-cycle pulse: advance ball one position.
- o_Ball_reset  out  1  one-cycle pulse: recenter ball.
- o_P1_score  out  4  player-1 score.
- o_P2_score  out  4  player-2 score.
- o_Winner  out  2  0 none, 1 P1, 2 P2; valid in GAMEOVER.
- o_State  out  3  current state encoding (debug/display).

## Operation
- States and encodings: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAMEOVER=4. Unused encodings return to IDLE on the next cycle.
- Start edge: start_rise = i_Start & ~start_q, where start_q is i_Start registered. start_q resets to 1 so a held button at reset does not start a game.
- IDLE: scores held at 0 and o_Winner=0. On start_rise, go to SERVE.
- SERVE: a frame counter clears on entry. Each i_Frame_end increments it. When the count reaches SERVE_FRAMES, go to PLAY and clear the step divider.
- PLAY: o_Game_active=1. Each i_Frame_end increments the divider. When the divider equals BALL_DIV-1, it wraps to 0 and o_Ball_step pulses.
- Miss handling in PLAY:
  - i_Miss_P2 alone: P1 score +1.
  - i_Miss_P1 alone: P2 score +1.
  - Both in the same cycle: no score change, go to POINT (replay).
  - Miss and i_Frame_end in the same cycle: the miss wins and no ball step is issued.
- After a score: if the new score equals SCORE_LIMIT, go to GAMEOVER and set o_Winner. Otherwise go to POINT.
- POINT: lasts exactly one cycle, then goes to SERVE.
- GAMEOVER: scores and o_Winner held. On start_rise, clear scores and o_Winner, then go to SERVE.
- Ignored inputs:
  - Miss pulses outside PLAY.
  - i_Frame_end outside SERVE/PLAY.
  - start_rise outside IDLE/GAMEOVER.
- Scores are 4-bit and cannot exceed SCORE_LIMIT, so they never wrap.

## Timing
- All outputs are registered.
- Reset values: state IDLE, o_Game_active=0, o_Ball_step=0, o_Ball_reset=0, both scores 0, o_Winner=0, o_State=0, internal counters 0.
- o_Ball_reset pulses for exactly one cycle, in the first cycle the state reads SERVE. It fires on every entry to SERVE (from IDLE, POINT and GAMEOVER).
- o_Ball_step is asserted in the cycle after the qualifying i_Frame_end, for one cycle.
- Miss to score latency: the miss sampled at edge N gives updated score and new state (POINT/GAMEOVER) visible after edge N.
- o_Game_active drops the cycle after the miss.
- SERVE duration: the state reads PLAY in the cycle after the SERVE_FRAMES-th i_Frame_end seen in SERVE.
- The i_Frame_end that arrives in the same cycle as entry into SERVE is not counted.
- o_Game_active rises on the same cycle o_State reads 2.
- i_Reset has priority over all inputs at any point (including mid-PLAY and GAMEOVER). Outputs take their reset values after the reset edge.

## Test plan
- Reset and start:
  - Assert i_Reset with i_Start held high, release, keep i_Start high: the state stays IDLE.
  - Drop i_Start, then raise it: the state reads SERVE, o_Ball_reset pulses one cycle, scores are 0.
- Serve and step rate (SERVE_FRAMES=3, BALL_DIV=2):
  - Drive i_Frame_end every 10 cycles: PLAY is entered after the third frame end.
  - o_Ball_step pulses on every 2nd frame end, one cycle late, never in SERVE.
- Scoring to game over (SCORE_LIMIT=3): pulse i_Miss_P2 three times in PLAY, re-serving between each.
  - Each point goes POINT → SERVE, with o_Ball_reset once per point.
  - The third point gives o_P1_score=3, GAMEOVER, o_Winner=1, o_Game_active=0.
- Simultaneous events:
  - i_Miss_P1 and i_Miss_P2 together: scores unchanged, POINT then SERVE.
  - A miss coinciding with a qualifying i_Frame_end: no o_Ball_step.
- Ignored inputs: miss pulses in IDLE, SERVE and GAMEOVER, and start_rise in PLAY, cause no score or state change.
- Restart and mid-game reset:
  - start_rise in GAMEOVER: scores clear, o_Winner=0, SERVE.
  - i_Reset asserted mid-PLAY with P2 score 2: next cycle IDLE, all outputs at reset values.
